// File: rtl/iso7816_act_seq_if.sv
// Signal bundle between the host/register side, the card pads and the
// ISO7816 session sequencer.
interface iso7816_act_seq_if;
    logic        cmd_activate;
    logic        cmd_deactivate;
    logic        cmd_warm_reset;
    logic [15:0] cfg_rst_hold;
    logic [15:0] cfg_atr_timeout;
    logic        card_clk_stb;
    logic        io_fall;
    logic        card_present;
    logic        card_vcc_en;
    logic        card_clk_en;
    logic        card_rst;
    logic        io_force_low;
    logic        core_rx_ena;
    logic        core_tx_ena;
    logic        busy;
    logic        active;
    logic        evt_stb;
    logic [1:0]  evt_code;

    modport master (
        output cmd_activate, cmd_deactivate, cmd_warm_reset,
        output cfg_rst_hold, cfg_atr_timeout,
        output card_clk_stb, io_fall, card_present,
        input  card_vcc_en, card_clk_en, card_rst, io_force_low,
        input  core_rx_ena, core_tx_ena, busy, active, evt_stb, evt_code
    );

    modport slave (
        input  cmd_activate, cmd_deactivate, cmd_warm_reset,
        input  cfg_rst_hold, cfg_atr_timeout,
        input  card_clk_stb, io_fall, card_present,
        output card_vcc_en, card_clk_en, card_rst, io_force_low,
        output core_rx_ena, core_tx_ena, busy, active, evt_stb, evt_code
    );
endinterface

// File: rtl/iso7816_act_seq.sv
// ISO7816-3 card session sequencer: cold activation, ATR watch, warm reset
// and orderly deactivation, with all pad/core controls registered.
module iso7816_act_seq #(
    parameter int T_STEP = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    iso7816_act_seq_if.slave  bus
);
    typedef enum logic [3:0] {
        S_OFF, S_VCC_UP, S_CLK_ON, S_ATR_WAIT, S_ACTIVE,
        S_WARM_RST, S_DEACT_RST, S_DEACT_CLK, S_DEACT_IO
    } state_e;

    localparam logic [15:0] STEP_N = (T_STEP < 1) ? 16'd1 : 16'(T_STEP);

    function automatic logic [15:0] load_n(input logic [15:0] n);
        return (n == 16'd0) ? 16'd1 : n;
    endfunction

    // {vcc, clk_en, rst, io_force_low, rx_ena, tx_ena, busy, active}
    function automatic logic [7:0] decode_out(input state_e s);
        case (s)
            S_VCC_UP:    return 8'b1000_0010;
            S_CLK_ON:    return 8'b1100_1010;
            S_ATR_WAIT:  return 8'b1110_1010;
            S_ACTIVE:    return 8'b1110_1101;
            S_WARM_RST:  return 8'b1100_1010;
            S_DEACT_RST: return 8'b1100_0010;
            S_DEACT_CLK: return 8'b1000_0010;
            S_DEACT_IO:  return 8'b1001_0010;
            default:     return 8'b0000_0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  pend_q, pend_d;
    logic        evt_stb_q, evt_stb_d;
    logic [1:0]  evt_code_q, evt_code_d;
    logic [7:0]  outs_q;
    logic        tick_s, expire_s, in_deact_s, abort_s;
    logic [1:0]  abort_code_s;

    // Tick source, timer expiry and abort requests for the current state
    always_comb begin
        tick_s     = 1'b0;
        in_deact_s = 1'b0;
        case (state_q)
            S_VCC_UP:                          tick_s = 1'b1;
            S_DEACT_RST, S_DEACT_CLK, S_DEACT_IO: begin
                tick_s     = 1'b1;
                in_deact_s = 1'b1;
            end
            S_CLK_ON, S_ATR_WAIT, S_WARM_RST:  tick_s = bus.card_clk_stb;
            default:                           tick_s = 1'b0;
        endcase
        expire_s     = tick_s && (timer_q == 16'd1);
        abort_s      = (state_q != S_OFF) && !in_deact_s &&
                       (!bus.card_present || bus.cmd_deactivate);
        abort_code_s = bus.card_present ? 2'b10 : 2'b11;
    end

    // Next-state, timer and event selection
    always_comb begin
        state_d    = state_q;
        timer_d    = tick_s ? (timer_q - 16'd1) : timer_q;
        pend_d     = (in_deact_s && !bus.card_present) ? 2'b11 : pend_q;
        evt_stb_d  = 1'b0;
        evt_code_d = evt_code_q;
        if (abort_s) begin
            state_d = S_DEACT_RST;
            timer_d = STEP_N;
            pend_d  = abort_code_s;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (bus.cmd_activate && bus.card_present) begin
                        state_d = S_VCC_UP;
                        timer_d = STEP_N;
                    end else begin
                        state_d = S_OFF;
                    end
                end
                S_VCC_UP: begin
                    if (expire_s) begin
                        state_d = S_CLK_ON;
                        timer_d = load_n(bus.cfg_rst_hold);
                    end else begin
                        state_d = S_VCC_UP;
                    end
                end
                S_CLK_ON, S_WARM_RST: begin
                    if (expire_s) begin
                        state_d = S_ATR_WAIT;
                        timer_d = load_n(bus.cfg_atr_timeout);
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ATR_WAIT: begin
                    // A character start on the expiry tick still counts as ATR
                    if (bus.io_fall) begin
                        state_d    = S_ACTIVE;
                        evt_stb_d  = 1'b1;
                        evt_code_d = 2'b00;
                    end else if (expire_s) begin
                        state_d = S_DEACT_RST;
                        timer_d = STEP_N;
                        pend_d  = 2'b01;
                    end else begin
                        state_d = S_ATR_WAIT;
                    end
                end
                S_ACTIVE: begin
                    if (bus.cmd_warm_reset) begin
                        state_d = S_WARM_RST;
                        timer_d = load_n(bus.cfg_rst_hold);
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
                S_DEACT_RST: begin
                    if (expire_s) begin
                        state_d = S_DEACT_CLK;
                        timer_d = STEP_N;
                    end else begin
                        state_d = S_DEACT_RST;
                    end
                end
                S_DEACT_CLK: begin
                    if (expire_s) begin
                        state_d = S_DEACT_IO;
                        timer_d = STEP_N;
                    end else begin
                        state_d = S_DEACT_CLK;
                    end
                end
                S_DEACT_IO: begin
                    if (expire_s) begin
                        state_d    = S_OFF;
                        evt_stb_d  = 1'b1;
                        evt_code_d = pend_d;
                        pend_d     = 2'b10;
                    end else begin
                        state_d = S_DEACT_IO;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    timer_d = 16'd0;
                end
            endcase
        end
    end

    // State, timer and output registers; outputs decode the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            timer_q    <= 16'd0;
            pend_q     <= 2'b10;
            evt_stb_q  <= 1'b0;
            evt_code_q <= 2'b00;
            outs_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            evt_stb_q  <= evt_stb_d;
            evt_code_q <= evt_code_d;
            outs_q     <= decode_out(state_d);
        end
    end

    assign bus.card_vcc_en  = outs_q[7];
    assign bus.card_clk_en  = outs_q[6];
    assign bus.card_rst     = outs_q[5];
    assign bus.io_force_low = outs_q[4];
    assign bus.core_rx_ena  = outs_q[3];
    assign bus.core_tx_ena  = outs_q[2];
    assign bus.busy         = outs_q[1];
    assign bus.active       = outs_q[0];
    assign bus.evt_stb      = evt_stb_q;
    assign bus.evt_code     = evt_code_q;
endmodule

// File: tb/tb_iso7816_act_seq.sv
// Bench for iso7816_act_seq: expected pad levels and events come from a
// phase timeline computed arithmetically from the card clock period.
module tb_iso7816_act_seq;
    localparam int TS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iso7816_act_seq_if bus_if ();
    iso7816_act_seq #(.T_STEP(TS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if.slave));

    typedef enum logic [3:0] {P_OFF, P_VCC, P_CLKON, P_ATR, P_ACT, P_WARM, P_DRST, P_DCLK, P_DIO} ph_t;

    int vectors = 0;
    int miscompares = 0;
    ph_t        seg_ph[$];
    int         seg_at[$];
    int         ev_at[$];
    logic [1:0] ev_code[$];

    // {vcc, clk_en, rst, io_force_low, rx, tx, busy, active}
    function automatic logic [7:0] ph_out(input ph_t p);
        case (p)
            P_VCC:   return 8'b1000_0010;
            P_CLKON: return 8'b1100_1010;
            P_ATR:   return 8'b1110_1010;
            P_ACT:   return 8'b1110_1101;
            P_WARM:  return 8'b1100_1010;
            P_DRST:  return 8'b1100_0010;
            P_DCLK:  return 8'b1000_0010;
            P_DIO:   return 8'b1001_0010;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Cycle of the k-th card clock strobe at or after cycle start
    function automatic int nth(input int start, input int per, input int k);
        int first;
        first = ((start + per - 1) / per) * per;
        return first + (k - 1) * per;
    endfunction

    function automatic void seg(input ph_t p, input int at);
        seg_ph.push_back(p);
        seg_at.push_back(at);
    endfunction

    function automatic void ev(input int at, input logic [1:0] code);
        ev_at.push_back(at);
        ev_code.push_back(code);
    endfunction

    function automatic logic [10:0] expect_at(input int n);
        ph_t p = P_OFF;
        logic stb = 1'b0;
        logic [1:0] code = 2'b00;
        for (int i = 0; i < seg_at.size(); i++)
            if (seg_at[i] <= n) p = seg_ph[i];
        for (int i = 0; i < ev_at.size(); i++)
            if (ev_at[i] == n) begin
                stb  = 1'b1;
                code = ev_code[i];
            end
        return {ph_out(p), stb, code};
    endfunction

    task automatic check(input string tag, input int n);
        logic [10:0] obs, exp_v;
        exp_v = expect_at(n);
        obs = {bus_if.card_vcc_en, bus_if.card_clk_en, bus_if.card_rst, bus_if.io_force_low,
               bus_if.core_rx_ena, bus_if.core_tx_ena, bus_if.busy, bus_if.active,
               bus_if.evt_stb, (bus_if.evt_stb ? bus_if.evt_code : 2'b00)};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, n, obs, exp_v);
        end
    endtask

    // end_kind: 0 deactivate, 1 removal+deactivate, 2 warm reset, 3 rst_n in ACTIVE
    task automatic scenario(input string tag, input int rh, input int to, input int per,
                            input int fall_k, input int end_kind, input bit noise,
                            input bit rm_atr, input bit nocard);
        int r_n, a_n, a, e1, b, e2, e3, f, f2, w, w2, d, rmv, rr, ds, last;
        logic [1:0] dcode;
        r_n = (rh == 0) ? 1 : rh;
        a_n = (to == 0) ? 1 : to;
        a = -1; e1 = -1; b = -1; f = -1; f2 = -1; w = -1; w2 = -1; d = -1; rr = -1; ds = -1;
        rmv = 1 << 30; dcode = 2'b10; last = 8;
        seg_ph.delete(); seg_at.delete(); ev_at.delete(); ev_code.delete();

        seg(P_OFF, 0);
        if (nocard) begin
            rmv = 0;
        end else begin
            seg(P_VCC, 1);
            a = TS + 1;
            seg(P_CLKON, a);
            e1 = nth(a, per, r_n);
            b = e1 + 1;
            seg(P_ATR, b);
            e2 = nth(b, per, a_n);
            if (rm_atr) begin
                rmv = b; d = b; ds = b + 1; dcode = 2'b11;
            end else if (fall_k == 0) begin
                ds = e2 + 1; dcode = 2'b01;
            end else begin
                f = nth(b, per, fall_k);
                seg(P_ACT, f + 1);
                ev(f + 1, 2'b00);
                case (end_kind)
                    0: begin d = f + 4; ds = d + 1; dcode = 2'b10; end
                    1: begin d = f + 4; rmv = d; ds = d + 1; dcode = 2'b11; end
                    2: begin
                        w = f + 3; w2 = w + 2;
                        seg(P_WARM, w + 1);
                        e3 = nth(w + 1, per, r_n);
                        seg(P_ATR, e3 + 1);
                        f2 = nth(e3 + 1, per, 1);
                        seg(P_ACT, f2 + 1);
                        ev(f2 + 1, 2'b00);
                        d = f2 + 4; ds = d + 1; dcode = 2'b10;
                    end
                    default: begin
                        rr = f + 3;
                        seg(P_OFF, rr + 1);
                        last = rr + 6;
                    end
                endcase
            end
            if (ds >= 0) begin
                seg(P_DRST, ds); seg(P_DCLK, ds + TS); seg(P_DIO, ds + 2 * TS); seg(P_OFF, ds + 3 * TS);
                ev(ds + 3 * TS, dcode);
                last = ds + 3 * TS + 4;
            end
        end

        bus_if.cmd_activate = 1'b0; bus_if.cmd_deactivate = 1'b0; bus_if.cmd_warm_reset = 1'b0;
        bus_if.io_fall = 1'b0; bus_if.card_present = 1'b1; bus_if.card_clk_stb = 1'b0;
        bus_if.cfg_rst_hold = 16'(rh); bus_if.cfg_atr_timeout = 16'(to);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check({tag, "_reset"}, -1);
        end
        rst_n = 1'b1;

        for (int n = 0; n <= last; n++) begin
            bus_if.cmd_activate   = (n == 0) || (noise && n == a);
            bus_if.io_fall        = (n == f) || (n == f2) || (noise && n >= a && n <= e1);
            bus_if.cmd_warm_reset = (n == w) || (n == w2) || (noise && n == b);
            bus_if.cmd_deactivate = (n == d);
            bus_if.card_present   = (n < rmv);
            bus_if.card_clk_stb   = ((n % per) == 0);
            rst_n                 = (n != rr);
            if (noise && n > a && n < e1) begin
                bus_if.cfg_rst_hold    = 16'($urandom_range(0, 65535));
                bus_if.cfg_atr_timeout = 16'($urandom_range(0, 65535));
            end else begin
                bus_if.cfg_rst_hold    = 16'(rh);
                bus_if.cfg_atr_timeout = 16'(to);
            end
            @(posedge clk); #1;
            check(tag, n + 1);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        scenario("cold_warm",     3, 10, 4, 5,  2, 1'b1, 1'b0, 1'b0);
        scenario("atr_timeout",   3, 10, 4, 0,  0, 1'b0, 1'b0, 1'b0);
        scenario("fall_at_exp",   3, 10, 4, 10, 0, 1'b0, 1'b0, 1'b0);
        scenario("rm_in_atr",     3, 10, 4, 0,  0, 1'b0, 1'b1, 1'b0);
        scenario("no_card",       3, 10, 4, 0,  0, 1'b0, 1'b0, 1'b1);
        scenario("rst_in_active", 3, 10, 4, 5,  3, 1'b0, 1'b0, 1'b0);
        scenario("rst_hold_zero", 0, 10, 4, 2,  0, 1'b0, 1'b0, 1'b0);
        scenario("rm_in_active",  3, 10, 4, 5,  1, 1'b0, 1'b0, 1'b0);
        for (int it = 0; it < 12; it++) begin
            int rh, to, per, a_n, fk, ek;
            rh  = int'($urandom_range(0, 6));
            to  = int'($urandom_range(0, 12));
            per = int'($urandom_range(1, 5));
            a_n = (to == 0) ? 1 : to;
            fk  = int'($urandom_range(0, a_n));
            ek  = int'($urandom_range(0, 3));
            scenario("random", rh, to, per, fk, ek, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
